// File: rtl/ram_loader.sv
// Byte-stream loader for the 16x8 program RAM: drives the RAM automatic-mode strobes and holds the
// CPU while loading. Define RAM_LOADER_VERIFY_EN to compile in per-byte readback verification.
module ram_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_addr_en,
  output logic              ram_load,
  output logic              ram_dataout_en,
  output logic              bus_drive,
  output logic [DATA_W-1:0] bus_data,
  input  logic [DATA_W-1:0] bus_in,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWaitByte,
    StWrite,
`ifdef RAM_LOADER_VERIFY_EN
    StVerify,
    StError,
`endif
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                at_last;

`ifdef RAM_LOADER_VERIFY_EN
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
`endif

  assign at_last = (ptr_q == last_q);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      last_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

`ifdef RAM_LOADER_VERIFY_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      err_addr_q <= '0;
    end else begin
      err_addr_q <= err_addr_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    hold_d  = hold_q;
`ifdef RAM_LOADER_VERIFY_EN
    err_addr_d = err_addr_q;
`endif
    unique case (state_q)
      StAddr: begin
        state_d = StWaitByte;
      end
      StWaitByte: begin
        if (byte_valid) begin
          hold_d  = byte_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
`ifdef RAM_LOADER_VERIFY_EN
        state_d = StVerify;
`else
        if (at_last) begin
          state_d = StDone;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = StAddr;
        end
`endif
      end
`ifdef RAM_LOADER_VERIFY_EN
      StVerify: begin
        if (bus_in != hold_q) begin
          err_addr_d = ptr_q;
          state_d    = StError;
        end else if (at_last) begin
          state_d = StDone;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = StAddr;
        end
      end
`endif
      // Idle, Done and Error are the only states that honour start.
      default: begin
        if (start) begin
          ptr_d   = '0;
          last_d  = last_addr;
          state_d = StAddr;
`ifdef RAM_LOADER_VERIFY_EN
          err_addr_d = '0;
`endif
        end
      end
    endcase
  end

  // All outputs decode from registered state only.
  always_comb begin
    byte_ready     = (state_q == StWaitByte);
    ram_addr       = ptr_q;
    ram_addr_en    = (state_q == StAddr);
    ram_load       = (state_q == StWrite);
    bus_drive      = (state_q == StWrite);
    bus_data       = bus_drive ? hold_q : '0;
    done           = (state_q == StDone);
`ifdef RAM_LOADER_VERIFY_EN
    ram_dataout_en = (state_q == StVerify);
    error          = (state_q == StError);
    err_addr       = err_addr_q;
    busy           = (state_q == StAddr) || (state_q == StWaitByte) || (state_q == StWrite) ||
                     (state_q == StVerify);
`else
    ram_dataout_en = 1'b0;
    error          = 1'b0;
    err_addr       = '0;
    busy           = (state_q == StAddr) || (state_q == StWaitByte) || (state_q == StWrite);
`endif
    cpu_hold       = busy || error;
  end

`ifndef RAM_LOADER_VERIFY_EN
  logic unused_bus_in;
  assign unused_bus_in = ^bus_in;
`endif

endmodule

// File: doc/ram_loader.md
# ram_loader

Sequencer that fills the 16 x 8 program RAM from a byte stream before the CPU runs, replacing hand-entry through the manual switches. It accepts bytes on a valid/ready handshake and drives the RAM's automatic-mode controls (address-register load, write, bus output enable) one byte at a time. It holds the CPU while loading. It optionally reads back each byte to verify it.

## Interface
Parameters:
- ADDR_W, 4, RAM address width; 2**ADDR_W words
- DATA_W, 8, RAM/bus word width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  reset, asynchronous, active-high
- start  in  1  begin a load; sampled only in IDLE, DONE or ERROR
- last_addr  in  ADDR_W  final address to write; sampled with start; load covers 0..last_addr
- byte_valid  in  1  byte_data is valid
- byte_data  in  DATA_W  stream byte
- byte_ready  out  1  loader accepts byte this cycle
- ram_addr  out  ADDR_W  address presented to RAM address register
- ram_addr_en  out  1  load RAM address register
- ram_load  out  1  write bus value into RAM at current address
- ram_dataout_en  out  1  RAM drives bus (readback)
- bus_drive  out  1  loader drives bus_data onto shared bus
- bus_data  out  DATA_W  value driven when bus_drive=1
- bus_in  in  DATA_W  shared bus value
- cpu_hold  out  1  CPU must not fetch/execute
- busy, done, error  out  1 each  status
- err_addr  out  ADDR_W  address of first readback mismatch

## Operation
- States: IDLE, ADDR, WAIT_BYTE, WRITE, VERIFY (only with macro), DONE, ERROR.
- IDLE/DONE/ERROR + start: ptr<=0, last<=last_addr, clear done/error, -> ADDR.
- ADDR: ram_addr=ptr, ram_addr_en=1 for exactly one cycle -> WAIT_BYTE.
- WAIT_BYTE: byte_ready=1; on byte_valid&byte_ready capture byte_data into hold register -> WRITE. byte_valid without ready is ignored; no byte is ever dropped or duplicated.
- WRITE: bus_drive=1, bus_data=hold, ram_load=1 for one cycle. Then -> VERIFY if enabled. Otherwise go to DONE if ptr==last, else ptr<=ptr+1 and -> ADDR.
- VERIFY: ram_dataout_en=1, bus_drive=0; bus_in compared with hold at end of cycle. On mismatch: err_addr<=ptr, -> ERROR. On match: same completion/advance rule as WRITE.
- ptr never wraps: last_addr=15 ends at 15; last_addr=0 loads one byte.
- bus_drive and ram_dataout_en are never both 1 (bus contention forbidden).
- ram_addr_en, ram_load, ram_dataout_en are mutually exclusive.
- busy=1 in ADDR/WAIT_BYTE/WRITE/VERIFY. done sticky in DONE. error sticky in ERROR. Both clear on start.
- cpu_hold=1 from start acceptance through load; 0 in DONE; stays 1 in ERROR until clr or new start.
- start while busy is ignored. Changes to last_addr while busy are ignored.

## Timing
- Reset (async, immediate): state IDLE, ptr=0, all outputs 0 (incl. cpu_hold, ram_load, bus_drive, err_addr).
- clr mid-write removes ram_load/bus_drive combinationally with clr; the partial byte is not guaranteed written.
- start accepted at edge N: ram_addr_en high cycle N+1, byte_ready high from N+2.
- Per byte: 3 cycles minimum (ADDR, WAIT_BYTE, WRITE), 4 with verify. Extra cycles equal valid stall.
- Full 16-byte load with byte_valid held high: 48 cycles start-to-DONE (64 with verify).
- All outputs are registered or decoded from state only; no input-to-output combinational path except async clr.

## Configuration
- RAM_LOADER_VERIFY_EN defined: VERIFY state compiled in; readback after each write; mismatch -> ERROR with err_addr.
- Undefined: no VERIFY state. ram_dataout_en is tied 0, error and err_addr are tied 0, and ERROR is unreachable.

## Test plan
- Load last_addr=1, bytes 0x0A, 0x1B, valid always high -> RAM[0]=0x0A, RAM[1]=0x1B; done=1, cpu_hold=0, 6 cycles (8 with verify).
- last_addr=15, bytes 0x00..0x0F, valid toggled every other cycle -> all 16 words correct, ptr stops at 15, no extra write.
- Verify build with RAM model forcing readback 0xFF at address 3 -> error=1, err_addr=3, cpu_hold=1; addresses 4..15 untouched.
- clr pulsed during WRITE of byte 5 -> all outputs 0 within same cycle; new start reloads from address 0 correctly.
- start pulsed while busy, and byte_valid asserted in IDLE -> both ignored; no extra ram_load pulses, byte count unchanged.
- Every cycle assertion: never bus_drive & ram_dataout_en; at most one of ram_addr_en/ram_load/ram_dataout_en high.
